// File: rtl/maquina_ctrl_param_pkg.sv
// Shared definitions for the FIFO-subsystem control machine: state codes,
// state width and the threshold reset value.
package maquina_pkg;

  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_RESET  = 3'd0,
    ST_INIT   = 3'd1,
    ST_IDLE   = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_ERROR  = 3'd4
  } estado_t;

  localparam logic [31:0] UMBRAL_RST_VAL = 32'd0;

endpackage

// File: rtl/maquina_ctrl_param_if.sv
// Bundle of threshold-programming, FIFO-status and state-flag signals between
// the controller (slave) and its environment (master).
interface maquina_ctrl_param_if #(
  parameter int N_FIFOS  = 5,
  parameter int UMBRAL_W = 3
);
  import maquina_pkg::*;

  logic                init;
  logic [UMBRAL_W-1:0] umbral_mf_in;
  logic [UMBRAL_W-1:0] umbral_vc_in;
  logic [UMBRAL_W-1:0] umbral_d_in;
  logic [N_FIFOS-1:0]  fifo_empties;
  logic [N_FIFOS-1:0]  fifo_errors;
  logic [UMBRAL_W-1:0] umbral_mf_out;
  logic [UMBRAL_W-1:0] umbral_vc_out;
  logic [UMBRAL_W-1:0] umbral_d_out;
  logic [N_FIFOS-1:0]  error_fifo;
  logic                error_out;
  logic                active_out;
  logic                idle_out;
  logic                init_out;
  logic [STATE_W-1:0]  estado_out;

  modport master (
    output init, umbral_mf_in, umbral_vc_in, umbral_d_in, fifo_empties, fifo_errors,
    input  umbral_mf_out, umbral_vc_out, umbral_d_out, error_fifo,
           error_out, active_out, idle_out, init_out, estado_out
  );

  modport slave (
    input  init, umbral_mf_in, umbral_vc_in, umbral_d_in, fifo_empties, fifo_errors,
    output umbral_mf_out, umbral_vc_out, umbral_d_out, error_fifo,
           error_out, active_out, idle_out, init_out, estado_out
  );

endinterface

// File: rtl/maquina_ctrl_param_contador_inactivo.sv
// Debounce counter for the ACTIVE->IDLE return: done fires on the all-empty
// cycle that completes a run of IDLE_CNT consecutive all-empty cycles.
module contador_inactivo #(
  parameter int IDLE_CNT = 4,
  parameter int CNT_W    = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic all_empty,
  input  logic enable,
  output logic done
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IDLE_CNT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Run completes when the counter already holds IDLE_CNT-1 empty cycles.
  always_comb begin
    done = enable & all_empty & (cnt_q == CNT_LAST);
  end

  // Next count: restart on clear, any busy cycle, or a completed run.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (!enable) begin
      cnt_d = cnt_q;
    end else if (!all_empty) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (done) begin
      cnt_d = {CNT_W{1'b0}};
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/maquina_ctrl_param.sv
// Control state machine for the switch FIFO subsystem: sequences RESET/INIT/
// IDLE/ACTIVE/ERROR, latches thresholds in INIT and keeps sticky FIFO errors.
module maquina_ctrl_param
  import maquina_pkg::*;
#(
  parameter int N_FIFOS  = 5,
  parameter int UMBRAL_W = 3,
  parameter int IDLE_CNT = 4,
  parameter int CNT_W    = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  maquina_ctrl_param_if.slave  bus
);

  localparam logic [UMBRAL_W-1:0] UMBRAL_RST = UMBRAL_RST_VAL[UMBRAL_W-1:0];

  estado_t             state_q, state_d;
  logic [UMBRAL_W-1:0] mf_q, mf_d;
  logic [UMBRAL_W-1:0] vc_q, vc_d;
  logic [UMBRAL_W-1:0] d_q, d_d;
  logic [N_FIFOS-1:0]  error_fifo_q, error_fifo_d;
  logic                error_q, error_d;
  logic                active_q, active_d;
  logic                idle_q, idle_d;
  logic                init_q, init_d;
  logic [STATE_W-1:0]  estado_q, estado_d;

  logic any_error_s;
  logic all_empty_s;
  logic cnt_clear_s;
  logic cnt_enable_s;
  logic idle_done_s;

  // FIFO status summaries and debounce counter control.
  always_comb begin
    any_error_s  = |bus.fifo_errors;
    all_empty_s  = &bus.fifo_empties;
    cnt_enable_s = (state_q == ST_ACTIVE);
    cnt_clear_s  = (state_q != ST_ACTIVE);
  end

  contador_inactivo #(
    .IDLE_CNT (IDLE_CNT),
    .CNT_W    (CNT_W)
  ) u_contador_inactivo (
    .clk       (clk),
    .reset     (reset),
    .clear     (cnt_clear_s),
    .all_empty (all_empty_s),
    .enable    (cnt_enable_s),
    .done      (idle_done_s)
  );

  // Next-state logic: errors first, then init, then per-state rules.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RESET: begin
        if (any_error_s) begin
          state_d = ST_ERROR;
        end else begin
          state_d = ST_INIT;
        end
      end
      ST_INIT: begin
        if (any_error_s) begin
          state_d = ST_ERROR;
        end else if (bus.init) begin
          state_d = ST_INIT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (any_error_s) begin
          state_d = ST_ERROR;
        end else if (bus.init) begin
          state_d = ST_INIT;
        end else if (!all_empty_s) begin
          state_d = ST_ACTIVE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACTIVE: begin
        if (any_error_s) begin
          state_d = ST_ERROR;
        end else if (bus.init) begin
          state_d = ST_INIT;
        end else if (idle_done_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_ACTIVE;
        end
      end
      ST_ERROR: begin
        state_d = ST_ERROR;
      end
      default: begin
        state_d = ST_RESET;
      end
    endcase
  end

  // Threshold capture in INIT and sticky error accumulation.
  always_comb begin
    if (state_q == ST_INIT) begin
      mf_d = bus.umbral_mf_in;
      vc_d = bus.umbral_vc_in;
      d_d  = bus.umbral_d_in;
    end else begin
      mf_d = mf_q;
      vc_d = vc_q;
      d_d  = d_q;
    end
    error_fifo_d = error_fifo_q | bus.fifo_errors;
  end

  // Flags decode the next state so that registered flags track state_q.
  always_comb begin
    error_d  = (state_d == ST_ERROR);
    active_d = (state_d == ST_ACTIVE);
    idle_d   = (state_d == ST_IDLE);
    init_d   = (state_d == ST_INIT);
    estado_d = state_d;
  end

  // State, threshold, error-mask and flag registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_RESET;
      mf_q         <= UMBRAL_RST;
      vc_q         <= UMBRAL_RST;
      d_q          <= UMBRAL_RST;
      error_fifo_q <= {N_FIFOS{1'b0}};
      error_q      <= 1'b0;
      active_q     <= 1'b0;
      idle_q       <= 1'b0;
      init_q       <= 1'b0;
      estado_q     <= ST_RESET;
    end else begin
      state_q      <= state_d;
      mf_q         <= mf_d;
      vc_q         <= vc_d;
      d_q          <= d_d;
      error_fifo_q <= error_fifo_d;
      error_q      <= error_d;
      active_q     <= active_d;
      idle_q       <= idle_d;
      init_q       <= init_d;
      estado_q     <= estado_d;
    end
  end

  assign bus.umbral_mf_out = mf_q;
  assign bus.umbral_vc_out = vc_q;
  assign bus.umbral_d_out  = d_q;
  assign bus.error_fifo    = error_fifo_q;
  assign bus.error_out     = error_q;
  assign bus.active_out    = active_q;
  assign bus.idle_out      = idle_q;
  assign bus.init_out      = init_q;
  assign bus.estado_out    = estado_q;

endmodule

// File: tb/tb_maquina_ctrl_param.sv
// Directed plus random bench for maquina_ctrl_param against a cycle-level
// behavioural model of the controller.
module tb_maquina_ctrl_param;

  localparam int N    = 5;
  localparam int UW   = 3;
  localparam int ICNT = 4;
  localparam int CW   = 3;

  localparam logic [N-1:0] ALL_E = 5'b11111;

  logic clk;
  logic reset;

  maquina_ctrl_param_if #(.N_FIFOS(N), .UMBRAL_W(UW)) bus ();

  maquina_ctrl_param #(
    .N_FIFOS (N),
    .UMBRAL_W(UW),
    .IDLE_CNT(ICNT),
    .CNT_W   (CW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // model: state code, length of current all-empty run in ACTIVE, regs
  int          m_st  = 0;
  int          m_run = 0;
  logic [N-1:0]  m_err = '0;
  logic [UW-1:0] m_mf = '0, m_vc = '0, m_d = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic in, input logic [UW-1:0] mf,
                      input logic [UW-1:0] vc, input logic [UW-1:0] d,
                      input logic [N-1:0] emp, input logic [N-1:0] errs);
    reset            = r;
    bus.init         = in;
    bus.umbral_mf_in = mf;
    bus.umbral_vc_in = vc;
    bus.umbral_d_in  = d;
    bus.fifo_empties = emp;
    bus.fifo_errors  = errs;
    if (r) begin
      m_st = 0; m_run = 0; m_err = '0; m_mf = '0; m_vc = '0; m_d = '0;
    end else begin
      m_err = m_err | errs;
      if (m_st == 1) begin
        m_mf = mf; m_vc = vc; m_d = d;
      end
      if (m_st == 4)          m_st = 4;
      else if (errs != '0)    m_st = 4;
      else if (m_st == 0)     m_st = 1;
      else if (in)            m_st = 1;
      else if (m_st == 1)     m_st = 2;
      else if (m_st == 2) begin
        if (emp != ALL_E) begin m_st = 3; m_run = 0; end
      end else if (m_st == 3) begin
        if (emp == ALL_E) begin
          m_run++;
          if (m_run == ICNT) begin m_st = 2; m_run = 0; end
        end else begin
          m_run = 0;
        end
      end
    end
    @(posedge clk);
    #1;
    chk("estado",     32'(bus.estado_out),    32'(m_st));
    chk("error_out",  32'(bus.error_out),     32'(m_st == 4));
    chk("active_out", 32'(bus.active_out),    32'(m_st == 3));
    chk("idle_out",   32'(bus.idle_out),      32'(m_st == 2));
    chk("init_out",   32'(bus.init_out),      32'(m_st == 1));
    chk("error_fifo", 32'(bus.error_fifo),    32'(m_err));
    chk("umbral_mf",  32'(bus.umbral_mf_out), 32'(m_mf));
    chk("umbral_vc",  32'(bus.umbral_vc_out), 32'(m_vc));
    chk("umbral_d",   32'(bus.umbral_d_out),  32'(m_d));
  endtask

  initial begin
    logic [N-1:0] emp_r, err_r;
    logic         rst_r, ini_r;

    reset = 1'b1;
    bus.init = 1'b0;
    bus.umbral_mf_in = '0; bus.umbral_vc_in = '0; bus.umbral_d_in = '0;
    bus.fifo_empties = ALL_E; bus.fifo_errors = '0;

    // 1: reset then programming 5/3/2
    step(1'b1, 1'b0, 3'd0, 3'd0, 3'd0, ALL_E, 5'b0);
    step(1'b1, 1'b0, 3'd0, 3'd0, 3'd0, ALL_E, 5'b0);
    chk("t1_reset_estado", 32'(bus.estado_out), 32'd0);
    step(1'b0, 1'b1, 3'd5, 3'd3, 3'd2, ALL_E, 5'b0);
    chk("t1_init_flag", 32'(bus.init_out), 32'd1);
    step(1'b0, 1'b1, 3'd5, 3'd3, 3'd2, ALL_E, 5'b0);
    step(1'b0, 1'b1, 3'd5, 3'd3, 3'd2, ALL_E, 5'b0);
    step(1'b0, 1'b0, 3'd5, 3'd3, 3'd2, ALL_E, 5'b0);
    chk("t1_idle_estado", 32'(bus.estado_out), 32'd2);
    step(1'b0, 1'b0, 3'd6, 3'd6, 3'd6, ALL_E, 5'b0);
    step(1'b0, 1'b0, 3'd1, 3'd1, 3'd1, ALL_E, 5'b0);
    chk("t1_mf_held", 32'(bus.umbral_mf_out), 32'd5);
    chk("t1_d_held",  32'(bus.umbral_d_out),  32'd2);

    // 2: traffic and debounce
    step(1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 5'b11101, 5'b0);
    chk("t2_active", 32'(bus.active_out), 32'd1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 3'd0, 3'd0, 3'd0, ALL_E, 5'b0);
    chk("t2_still_active", 32'(bus.active_out), 32'd1);
    step(1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 5'b01111, 5'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 3'd0, 3'd0, 3'd0, ALL_E, 5'b0);
    chk("t2_active_3rd", 32'(bus.active_out), 32'd1);
    step(1'b0, 1'b0, 3'd0, 3'd0, 3'd0, ALL_E, 5'b0);
    chk("t2_idle_4th", 32'(bus.idle_out), 32'd1);

    // 3: error capture and absorption
    step(1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 5'b11110, 5'b0);
    step(1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 5'b11110, 5'b00100);
    chk("t3_error", 32'(bus.error_out), 32'd1);
    chk("t3_mask1", 32'(bus.error_fifo), 32'h04);
    step(1'b0, 1'b0, 3'd0, 3'd0, 3'd0, ALL_E, 5'b0);
    step(1'b0, 1'b0, 3'd0, 3'd0, 3'd0, ALL_E, 5'b10000);
    chk("t3_mask2", 32'(bus.error_fifo), 32'h14);
    step(1'b0, 1'b1, 3'd0, 3'd0, 3'd0, ALL_E, 5'b0);
    chk("t3_init_ignored", 32'(bus.estado_out), 32'd4);
    step(1'b1, 1'b0, 3'd0, 3'd0, 3'd0, ALL_E, 5'b00010);
    chk("t3_reset_mask", 32'(bus.error_fifo), 32'd0);

    // 4: error beats init
    step(1'b0, 1'b0, 3'd4, 3'd4, 3'd4, ALL_E, 5'b0);
    step(1'b0, 1'b0, 3'd4, 3'd4, 3'd4, ALL_E, 5'b0);
    step(1'b0, 1'b1, 3'd4, 3'd4, 3'd4, ALL_E, 5'b00001);
    chk("t4_priority", 32'(bus.estado_out), 32'd4);

    // 5: re-init from ACTIVE
    step(1'b1, 1'b0, 3'd0, 3'd0, 3'd0, ALL_E, 5'b0);
    step(1'b0, 1'b0, 3'd3, 3'd3, 3'd3, ALL_E, 5'b0);
    step(1'b0, 1'b0, 3'd3, 3'd3, 3'd3, ALL_E, 5'b0);
    step(1'b0, 1'b0, 3'd3, 3'd3, 3'd3, 5'b00000, 5'b0);
    step(1'b0, 1'b1, 3'd7, 3'd3, 3'd3, 5'b00000, 5'b0);
    chk("t5_init", 32'(bus.init_out), 32'd1);
    step(1'b0, 1'b1, 3'd7, 3'd3, 3'd3, ALL_E, 5'b0);
    chk("t5_mf7", 32'(bus.umbral_mf_out), 32'd7);
    step(1'b0, 1'b0, 3'd7, 3'd3, 3'd3, ALL_E, 5'b0);
    chk("t5_idle", 32'(bus.idle_out), 32'd1);

    // 6: reset in the middle of INIT
    step(1'b0, 1'b1, 3'd6, 3'd5, 3'd4, ALL_E, 5'b0);
    step(1'b0, 1'b1, 3'd6, 3'd5, 3'd4, ALL_E, 5'b0);
    step(1'b1, 1'b1, 3'd6, 3'd5, 3'd4, ALL_E, 5'b0);
    chk("t6_estado", 32'(bus.estado_out), 32'd0);
    chk("t6_mf0",    32'(bus.umbral_mf_out), 32'd0);

    // random traffic against the model
    for (int i = 0; i < 600; i++) begin
      rst_r = ($urandom_range(0, 70) == 0);
      ini_r = ($urandom_range(0, 12) == 0);
      err_r = ($urandom_range(0, 50) == 0) ? N'($urandom) : '0;
      emp_r = ($urandom_range(0, 2) != 0) ? ALL_E : N'($urandom);
      step(rst_r, ini_r, UW'($urandom), UW'($urandom), UW'($urandom), emp_r, err_r);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
